// File: rtl/core_pkg.sv
// Shared definitions for the branch datapath: FSM states, default operand
// width, and the funct3 encodings of the conditional branches.
package core_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } cmp_state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Branch-unit helper: turns the comparator flags into a taken decision.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       lt,
                                          input logic       ltu);
        logic taken;
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_chunk_cmp.sv
// Combinational compare of one CHUNK-wide slice. The top slice carries the
// sign bit, so its signed compare flips both MSBs and compares unsigned.
module branch_chunk_cmp #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             is_top,
    output logic             eq,
    output logic             ltu,
    output logic             lt
);

    logic [CHUNK-1:0] a_s;
    logic [CHUNK-1:0] b_s;

    // Equality, unsigned order, and sign-aware order for the top slice.
    always_comb begin
        a_s            = a;
        b_s            = b;
        a_s[CHUNK-1]   = ~a[CHUNK-1];
        b_s[CHUNK-1]   = ~b[CHUNK-1];
        eq             = (a == b);
        ltu            = (a < b);
        lt             = is_top ? (a_s < b_s) : (a < b);
    end

endmodule

// File: rtl/branch_compare_serial.sv
// Serial rs1/rs2 comparator: walks chunks from the most significant end and
// stops at the first difference, producing Zero / LessThan / LessThanUnsigned
// behind a start/busy/done handshake. CHUNK must divide XLEN.
module branch_compare_serial
    import core_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic            Zero,
    output logic            LessThan,
    output logic            LessThanUnsigned
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    cmp_state_e       state_q, state_d;
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             lt_q, lt_d;
    logic             ltu_q, ltu_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_eq;
    logic             chunk_ltu;
    logic             chunk_lt;

    assign a_chunk = a_q[int'(idx_q)*CHUNK +: CHUNK];
    assign b_chunk = b_q[int'(idx_q)*CHUNK +: CHUNK];

    branch_chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .a      (a_chunk),
        .b      (b_chunk),
        .is_top (idx_q == IDX_TOP),
        .eq     (chunk_eq),
        .ltu    (chunk_ltu),
        .lt     (chunk_lt)
    );

    // Next-state, operand capture, index walk and flag update.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        zero_d  = zero_q;
        lt_d    = lt_q;
        ltu_d   = ltu_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = rs1;
                    b_d     = rs2;
                    idx_d   = IDX_TOP;
                    busy_d  = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (!chunk_eq) begin
                    zero_d  = 1'b0;
                    ltu_d   = chunk_ltu;
                    lt_d    = chunk_lt;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    zero_d  = 1'b1;
                    ltu_d   = 1'b0;
                    lt_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and flag registers, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            lt_q    <= 1'b0;
            ltu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
            lt_q    <= lt_d;
            ltu_q   <= ltu_d;
        end
    end

    // Operand registers: loaded on start, only read while in CMP.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; they are always written before they are read.
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign Zero             = zero_q;
    assign LessThan         = lt_q;
    assign LessThanUnsigned = ltu_q;

endmodule

// File: doc/branch_compare_serial.md
# branch_compare_serial

Multi-cycle operand comparator that produces the `Zero`, `LessThan` and `LessThanUnsigned` flags consumed by the branch decision logic. It sits between the register-file read stage and the branch unit. It compares `rs1` against `rs2` one chunk at a time, most-significant chunk first, and terminates early on the first differing chunk. A start/busy/done handshake lets the control FSM stall the core while the compare runs.

## Interface
- `XLEN`, default 32: operand width.
- `CHUNK`, default 4: bits compared per cycle. Must divide `XLEN`. `NCHUNK = XLEN/CHUNK`.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request a compare. Sampled only when idle (`busy`=0).
- `rs1` in XLEN: left operand. Sampled with `start`.
- `rs2` in XLEN: right operand. Sampled with `start`.
- `busy` out 1: high while a compare is in progress.
- `done` out 1: one-cycle pulse; flags are valid from this cycle on.
- `Zero` out 1: `rs1 == rs2`.
- `LessThan` out 1: `rs1 < rs2`, signed two's complement.
- `LessThanUnsigned` out 1: `rs1 < rs2`, unsigned.

## Operation
- FSM states: `IDLE`, `CMP`.
- Reset: state `IDLE`; `busy`, `done`, `Zero`, `LessThan`, `LessThanUnsigned` all 0; index 0. Reset overrides every other event.
- `IDLE`:
  - If `start`=1, latch `rs1` and `rs2` into operand registers, set index to `NCHUNK-1` and `busy`=1, then go to `CMP`.
  - Otherwise hold. Flags keep their last values.
- `CMP`: compare `a[idx]` against `b[idx]` (chunk `idx` = bits `[idx*CHUNK +: CHUNK]`).
  - Chunks differ: `Zero`=0 and `LessThanUnsigned` = `a_chunk < b_chunk`.
    - If `idx == NCHUNK-1`: `LessThan` = unsigned compare of both chunks with their MSB inverted.
    - Otherwise `LessThan` = `LessThanUnsigned`, because the signs are already equal.
    - Then `done`=1, `busy`=0, go to `IDLE`.
  - Chunks equal and `idx == 0`: `Zero`=1, `LessThan`=0, `LessThanUnsigned`=0, `done`=1, `busy`=0, go to `IDLE`.
  - Chunks equal and `idx > 0`: decrement `idx`, stay in `CMP`.
- `done` is a registered pulse and clears on the next edge unless another compare finishes on that edge.
- `start` while `busy`=1 is ignored. The operand registers are not disturbed.
- The flags change only at the edge that finishes a compare, and are held until the next finish or reset.
- `rs1` and `rs2` may change freely after the `start` edge.

## Timing
- Define E0 as the edge at which `start` is sampled in `IDLE`. `busy`=1 from E0.
- If the first differing chunk is the k-th examined (k = 1..NCHUNK), the flags update and `done`=1 at edge E0+k. `busy`=0 at that same edge.
- Equal operands take `NCHUNK` cycles: `done` at E0+`NCHUNK`.
- Best case is 1 cycle (top chunk differs). Worst case is `NCHUNK` cycles (8 at the defaults).
- Back-to-back operation: `start` high in the `done` cycle is accepted, because the FSM is already in `IDLE`. The next result can arrive one cycle later at the earliest.
- Reset asserted mid-compare: at that edge the FSM returns to `IDLE`, `busy`=0 and flags clear to 0. No `done` pulse is issued for the aborted compare.
- No combinational path from any input to any output.

## Structure
- Shared package `core_pkg` holds:
  - the state enum (`IDLE`, `CMP`);
  - the `XLEN` default;
  - the `funct3` branch encodings: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
- Sub-module `branch_chunk_cmp`: purely combinational, `CHUNK`-wide.
  - Inputs: `a`, `b`, `is_top`.
  - Outputs: `eq`, `ltu`, `lt`.
  - `lt` applies MSB inversion when `is_top`=1.
- Top level holds the FSM, the operand registers, the index counter and the flag registers.

## Test plan
All cases use `XLEN`=32, `CHUNK`=4 (`NCHUNK`=8).
- `rs1`=`rs2`=0x1234_5678 -> `done` at E0+8; `Zero`=1, `LessThan`=0, `LessThanUnsigned`=0; `busy` high for exactly 8 cycles.
- `rs1`=0xFFFF_FFFF, `rs2`=0x0000_0001 -> `done` at E0+1; `Zero`=0, `LessThan`=1, `LessThanUnsigned`=0.
- `rs1`=0x8000_0000, `rs2`=0x7FFF_FFFF -> `done` at E0+1; `LessThan`=1, `LessThanUnsigned`=0. Swap the operands -> `LessThan`=0, `LessThanUnsigned`=1.
- `rs1`=0x0000_0005, `rs2`=0x0000_0007 -> `done` at E0+8; `Zero`=0, `LessThan`=1, `LessThanUnsigned`=1.
- Handshake cases:
  - `start` with new operands at E0+3 of a running compare -> ignored; the original result is produced.
  - `start` in the `done` cycle -> accepted; the second result is correct.
- Start the compare from the first case, then `rst_n`=0 at E0+3 -> `busy`=0 and all flags 0 at that edge; no `done` pulse; a fresh compare afterwards behaves normally.
